johnson_seq: RTL and testbench

//  Parametrised Johnson (inverted ring) counter sequencer: STAGES flops give 2*STAGES steps,

---
 rtl/johnson_seq_if.sv | 29 ++
 rtl/johnson_seq.sv | 147 ++++++++++++++
 tb/tb_johnson_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/johnson_seq_if.sv
// Control and status bundle for the johnson_seq step sequencer.
// The master side drives the step controls; the slave side is the sequencer itself.
interface johnson_seq_if #(
    parameter int STAGES = 4
);
    localparam int NSTEP = 2 * STAGES;
    localparam int SW    = $clog2(NSTEP);

    logic              EN;
    logic              DIR;
    logic              CLR;
    logic              ONESHOT;
    logic [STAGES-1:0] Q;
    logic [NSTEP-1:0]  DECODED;
    logic [SW-1:0]     STEP;
    logic              WRAP;
    logic              HALT;
    logic              ERR;

    modport master (
        output EN, DIR, CLR, ONESHOT,
        input  Q, DECODED, STEP, WRAP, HALT, ERR
    );

    modport slave (
        input  EN, DIR, CLR, ONESHOT,
        output Q, DECODED, STEP, WRAP, HALT, ERR
    );
endinterface

// File: rtl/johnson_seq.sv
// Parametrised Johnson-ring step sequencer with one-hot and binary step decode.
// Optional macro JOHNSON_SELFCORRECT_EN adds illegal-state detection, recovery and a sticky ERR.
module johnson_seq #(
    parameter int STAGES = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    johnson_seq_if.slave bus
);
    localparam int NSTEP = 2 * STAGES;
    localparam int SW    = $clog2(NSTEP);

    // Binary index of the set bit; an all-zero vector encodes as step 0.
    function automatic logic [SW-1:0] encode_step(input logic [NSTEP-1:0] v);
        logic [SW-1:0] acc;
        acc = {SW{1'b0}};
        for (int i = 0; i < NSTEP; i++) begin
            if (v[i]) begin
                acc = acc | SW'(i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    logic [STAGES-1:0] q_r;
    logic              wrap_r;
    logic              halt_r;

    logic [NSTEP-1:0]  raw_dec_s;
    logic [NSTEP-1:0]  decoded_s;
    logic [STAGES-1:0] fwd_q_s;
    logic [STAGES-1:0] bwd_q_s;
    logic [STAGES-1:0] step_q_s;
    logic              at_term_s;
    logic              corr_s;
    logic [STAGES-1:0] q_nxt_s;
    logic              wrap_nxt_s;
    logic              halt_nxt_s;

    // Each step is recognised by the boundary between the ones and zeros in the ring.
    for (genvar k = 0; k < STAGES; k++) begin : g_dec
        if (k == 0) begin : g_first
            assign raw_dec_s[0]      = ~q_r[STAGES-1] & ~q_r[0];
            assign raw_dec_s[STAGES] =  q_r[STAGES-1] &  q_r[0];
        end else begin : g_rest
            assign raw_dec_s[k]        =  q_r[k-1] & ~q_r[k];
            assign raw_dec_s[STAGES+k] = ~q_r[k-1] &  q_r[k];
        end
    end

    assign fwd_q_s   = {q_r[STAGES-2:0], ~q_r[STAGES-1]};
    assign bwd_q_s   = {~q_r[0], q_r[STAGES-1:1]};
    assign step_q_s  = bus.DIR ? bwd_q_s : fwd_q_s;
    assign at_term_s = bus.DIR ? raw_dec_s[0] : raw_dec_s[NSTEP-1];

    // Decode is gated by reset directly so downstream strobes drop without waiting for a clock.
    assign decoded_s = RESET ? raw_dec_s : {NSTEP{1'b0}};

`ifdef JOHNSON_SELFCORRECT_EN
    // True when exactly one bit of the vector is set.
    function automatic logic is_onehot(input logic [NSTEP-1:0] v);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < NSTEP; i++) begin
            if (v[i] && seen) begin
                multi = 1'b1;
            end else if (v[i]) begin
                seen = 1'b1;
            end else begin
                seen = seen;
            end
        end
        return seen & ~multi;
    endfunction

    logic err_r;

    assign corr_s = ~is_onehot(raw_dec_s);

    // Sticky illegal-state flag; only RESET clears it.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            err_r <= 1'b0;
        end else if (corr_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign bus.ERR = err_r;
`else
    assign corr_s  = 1'b0;
    assign bus.ERR = 1'b0;
`endif

    // Next-state selection: correction, then clear, then stepping, else hold.
    always_comb begin
        q_nxt_s    = q_r;
        wrap_nxt_s = 1'b0;
        halt_nxt_s = halt_r;
        if (corr_s) begin
            q_nxt_s    = {STAGES{1'b0}};
            halt_nxt_s = 1'b0;
        end else if (bus.CLR) begin
            q_nxt_s    = {STAGES{1'b0}};
            halt_nxt_s = 1'b0;
        end else if (bus.EN) begin
            if (at_term_s && bus.ONESHOT) begin
                halt_nxt_s = 1'b1;
            end else if (at_term_s) begin
                q_nxt_s    = step_q_s;
                wrap_nxt_s = 1'b1;
                halt_nxt_s = 1'b0;
            end else begin
                q_nxt_s    = step_q_s;
                halt_nxt_s = 1'b0;
            end
        end else begin
            // A parked sequencer is released as soon as one-shot mode is dropped.
            halt_nxt_s = halt_r & bus.ONESHOT;
        end
    end

    // Ring flops and registered status flags.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            q_r    <= {STAGES{1'b0}};
            wrap_r <= 1'b0;
            halt_r <= 1'b0;
        end else begin
            q_r    <= q_nxt_s;
            wrap_r <= wrap_nxt_s;
            halt_r <= halt_nxt_s;
        end
    end

    assign bus.Q       = q_r;
    assign bus.DECODED = decoded_s;
    assign bus.STEP    = encode_step(decoded_s);
    assign bus.WRAP    = wrap_r;
    assign bus.HALT    = halt_r;
endmodule

// File: tb/tb_johnson_seq.sv
// Directed self-checking bench for johnson_seq at STAGES = 4, 2 and 16.
module tb_johnson_seq;
    logic CLK;
    logic RESET;

    johnson_seq_if #(.STAGES(4))  b4 ();
    johnson_seq_if #(.STAGES(2))  b2 ();
    johnson_seq_if #(.STAGES(16)) b16 ();

    johnson_seq #(.STAGES(4))  u4  (.CLK(CLK), .RESET(RESET), .bus(b4));
    johnson_seq #(.STAGES(2))  u2  (.CLK(CLK), .RESET(RESET), .bus(b2));
    johnson_seq #(.STAGES(16)) u16 (.CLK(CLK), .RESET(RESET), .bus(b16));

    int         n_checks;
    int         n_fail;
    int         exp_s;
    logic [3:0] qtab4 [8];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Steps the 4-stage sequencer n times in one direction, checking each step.
    task automatic walk4(input string tag, input int n, input logic dir);
        int prev;
        b4.DIR = dir;
        for (int i = 0; i < n; i++) begin
            tick();
            prev  = exp_s;
            exp_s = dir ? (exp_s + 7) % 8 : (exp_s + 1) % 8;
            check_eq({tag, "_step"}, 64'(b4.STEP), 64'(exp_s));
            check_eq({tag, "_dec"}, 64'(b4.DECODED), 64'd1 << exp_s);
            check_eq({tag, "_q"}, 64'(b4.Q), 64'(qtab4[exp_s]));
            check_eq({tag, "_wrap"}, 64'(b4.WRAP), dir ? 64'(prev == 0) : 64'(prev == 7));
        end
    endtask

    initial begin
        int e2;
        int e16;
        n_checks = 0;
        n_fail   = 0;
        qtab4 = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        RESET = 1'b0;
        b4.EN  = 1'b0; b4.DIR  = 1'b0; b4.CLR  = 1'b0; b4.ONESHOT  = 1'b0;
        b2.EN  = 1'b0; b2.DIR  = 1'b0; b2.CLR  = 1'b0; b2.ONESHOT  = 1'b0;
        b16.EN = 1'b0; b16.DIR = 1'b0; b16.CLR = 1'b0; b16.ONESHOT = 1'b0;

        // Reset state
        tick();
        tick();
        check_eq("rst_q", 64'(b4.Q), 64'h0);
        check_eq("rst_wrap", 64'(b4.WRAP), 64'h0);
        check_eq("rst_halt", 64'(b4.HALT), 64'h0);
        check_eq("rst_err", 64'(b4.ERR), 64'h0);
        check_eq("rst_dec_gated", 64'(b4.DECODED), 64'h0);
        check_eq("rst_step_gated", 64'(b4.STEP), 64'h0);
        RESET = 1'b1;
        #1;
        check_eq("rel_dec", 64'(b4.DECODED), 64'h01);
        check_eq("rel_step", 64'(b4.STEP), 64'h0);

        // T1: two forward laps
        exp_s = 0;
        b4.EN = 1'b1;
        walk4("t1", 16, 1'b0);

        // T2: forward to 3, then backward through the wrap
        walk4("t2f", 3, 1'b0);
        walk4("t2b", 4, 1'b1);
        check_eq("t2_q_end", 64'(b4.Q), 64'h8);

        // T3: one-shot stops at the terminal step
        b4.CLR = 1'b1;
        tick();
        check_eq("t3_clr_step", 64'(b4.STEP), 64'h0);
        check_eq("t3_clr_q", 64'(b4.Q), 64'h0);
        b4.CLR     = 1'b0;
        b4.DIR     = 1'b0;
        b4.ONESHOT = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_eq("t3_step", 64'(b4.STEP), (i < 7) ? 64'(i) : 64'd7);
            check_eq("t3_halt", 64'(b4.HALT), 64'(i >= 8));
            check_eq("t3_wrap", 64'(b4.WRAP), 64'h0);
        end
        b4.ONESHOT = 1'b0;
        tick();
        check_eq("t3_rel_step", 64'(b4.STEP), 64'h0);
        check_eq("t3_rel_wrap", 64'(b4.WRAP), 64'h1);
        check_eq("t3_rel_halt", 64'(b4.HALT), 64'h0);

        // T4: hold, clear, and reset mid-run
        exp_s = 0;
        walk4("t4", 5, 1'b0);
        b4.EN = 1'b0;
        tick();
        check_eq("t4_hold_step", 64'(b4.STEP), 64'h5);
        check_eq("t4_hold_wrap", 64'(b4.WRAP), 64'h0);
        b4.EN  = 1'b1;
        b4.CLR = 1'b1;
        tick();
        check_eq("t4_clr_step", 64'(b4.STEP), 64'h0);
        check_eq("t4_clr_q", 64'(b4.Q), 64'h0);
        b4.CLR = 1'b0;
        exp_s  = 0;
        walk4("t4r", 2, 1'b0);
        RESET = 1'b0;
        #1;
        check_eq("t4_rst_dec_now", 64'(b4.DECODED), 64'h0);
        check_eq("t4_rst_step_now", 64'(b4.STEP), 64'h0);
        check_eq("t4_rst_q_pre", 64'(b4.Q), 64'h3);
        b4.EN = 1'b0;
        tick();
        check_eq("t4_rst_q", 64'(b4.Q), 64'h0);
        RESET = 1'b1;
        #1;
        check_eq("t4_rel_dec", 64'(b4.DECODED), 64'h01);

        // T5: illegal ring pattern
        force u4.q_r = 4'b0101;
        #1;
        release u4.q_r;
        #1;
        check_eq("t5_forced_q", 64'(b4.Q), 64'h5);
        b4.EN  = 1'b1;
        b4.DIR = 1'b0;
        tick();
`ifdef JOHNSON_SELFCORRECT_EN
        check_eq("t5_corr_q", 64'(b4.Q), 64'h0);
        check_eq("t5_err_set", 64'(b4.ERR), 64'h1);
        tick();
        check_eq("t5_resume_q", 64'(b4.Q), 64'h1);
        check_eq("t5_err_sticky", 64'(b4.ERR), 64'h1);
`else
        check_eq("t5_para_q1", 64'(b4.Q), 64'hB);
        check_eq("t5_err_zero", 64'(b4.ERR), 64'h0);
        tick();
        check_eq("t5_para_q2", 64'(b4.Q), 64'h6);
`endif
        b4.CLR = 1'b1;
        tick();
        check_eq("t5_clr_q", 64'(b4.Q), 64'h0);
        check_eq("t5_clr_step", 64'(b4.STEP), 64'h0);
`ifdef JOHNSON_SELFCORRECT_EN
        check_eq("t5_err_after_clr", 64'(b4.ERR), 64'h1);
`endif
        b4.CLR = 1'b0;
        b4.EN  = 1'b0;
        RESET  = 1'b0;
        tick();
        check_eq("t5_err_rst", 64'(b4.ERR), 64'h0);
        RESET = 1'b1;

        // T6: full forward and backward loops for 2 and 16 stages
        b2.EN  = 1'b1;
        b16.EN = 1'b1;
        e2  = 0;
        e16 = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            e2  = i % 4;
            e16 = i % 32;
            check_eq("t6f_s2_step", 64'(b2.STEP), 64'(e2));
            check_eq("t6f_s2_dec", 64'(b2.DECODED), 64'd1 << e2);
            check_eq("t6f_s16_step", 64'(b16.STEP), 64'(e16));
            check_eq("t6f_s16_dec", 64'(b16.DECODED), 64'd1 << e16);
        end
        check_eq("t6f_s16_wrap", 64'(b16.WRAP), 64'h1);
        b2.DIR  = 1'b1;
        b16.DIR = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            e2  = (e2 + 3) % 4;
            e16 = (e16 + 31) % 32;
            check_eq("t6b_s2_step", 64'(b2.STEP), 64'(e2));
            check_eq("t6b_s2_dec", 64'(b2.DECODED), 64'd1 << e2);
            check_eq("t6b_s16_step", 64'(b16.STEP), 64'(e16));
            check_eq("t6b_s16_dec", 64'(b16.DECODED), 64'd1 << e16);
        end
        check_eq("t6b_s16_q", 64'(b16.Q), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
